// File: rtl/clasif_stats.sv
// Windowed flag statistics for the 5-bit number classifier: counts p/x/t flags over WINDOW samples.
// Optional macro CLS_NONE_EN adds cnt_none, counting samples with no flag set.
module clasif_stats #(
  parameter int WINDOW = 16,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          p_in,
  input  logic          x_in,
  input  logic          t_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt_p,
  output logic [CW-1:0] cnt_x,
  output logic [CW-1:0] cnt_t
`ifdef CLS_NONE_EN
  ,
  output logic [CW-1:0] cnt_none
`endif
);

  localparam int SCW = $clog2(WINDOW + 1);
  localparam logic [SCW-1:0] LAST_IDX = SCW'(WINDOW - 1);

  typedef enum logic {COLLECT, REPORT} state_t;

  state_t         state;
  state_t         next_state;
  logic [SCW-1:0] sample_cnt;
  logic [CW-1:0]  acc_p;
  logic [CW-1:0]  acc_x;
  logic [CW-1:0]  acc_t;
  logic           accept;
  logic           last_sample;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic f);
    if (f && (v != {CW{1'b1}}))
      return v + CW'(1);
    else
      return v;
  endfunction

  assign accept      = in_valid & in_ready;
  assign last_sample = accept & (sample_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= COLLECT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = COLLECT;
    end else begin
      case (state)
        COLLECT: if (last_sample) next_state = REPORT;
        REPORT:  if (out_ready)   next_state = COLLECT;
        default: next_state = COLLECT;
      endcase
    end
  end

  // Handshake flags depend only on the registered state, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state == COLLECT);
    out_valid = (state == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      acc_p      <= '0;
      acc_x      <= '0;
      acc_t      <= '0;
      cnt_p      <= '0;
      cnt_x      <= '0;
      cnt_t      <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      acc_p      <= '0;
      acc_x      <= '0;
      acc_t      <= '0;
      cnt_p      <= '0;
      cnt_x      <= '0;
      cnt_t      <= '0;
    end else if (accept) begin
      if (last_sample) begin
        cnt_p      <= sat_inc(acc_p, p_in);
        cnt_x      <= sat_inc(acc_x, x_in);
        cnt_t      <= sat_inc(acc_t, t_in);
        acc_p      <= '0;
        acc_x      <= '0;
        acc_t      <= '0;
        sample_cnt <= '0;
      end else begin
        acc_p      <= sat_inc(acc_p, p_in);
        acc_x      <= sat_inc(acc_x, x_in);
        acc_t      <= sat_inc(acc_t, t_in);
        sample_cnt <= sample_cnt + SCW'(1);
      end
    end
  end

`ifdef CLS_NONE_EN
  logic [CW-1:0] acc_none;
  logic          none_flag;

  assign none_flag = ~(p_in | x_in | t_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_none <= '0;
      cnt_none <= '0;
    end else if (clr) begin
      acc_none <= '0;
      cnt_none <= '0;
    end else if (accept) begin
      if (last_sample) begin
        cnt_none <= sat_inc(acc_none, none_flag);
        acc_none <= '0;
      end else begin
        acc_none <= sat_inc(acc_none, none_flag);
      end
    end
  end
`endif

endmodule

// File: tb/tb_clasif_stats.sv
// Directed bench for clasif_stats: a WINDOW=4/CW=8 instance for the main flow and a
// WINDOW=10/CW=3 instance for count saturation.
module tb_clasif_stats;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic       p_in;
  logic       x_in;
  logic       t_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cnt_p;
  logic [7:0] cnt_x;
  logic [7:0] cnt_t;

  logic       s_in_valid;
  logic       s_in_ready;
  logic       s_p_in;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [2:0] s_cnt_p;
  logic [2:0] s_cnt_x;
  logic [2:0] s_cnt_t;

`ifdef CLS_NONE_EN
  logic [7:0] cnt_none;
  logic [2:0] s_cnt_none;
`endif

  int vectors;
  int miscompares;

  clasif_stats #(.WINDOW(4), .CW(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_in      (p_in),
    .x_in      (x_in),
    .t_in      (t_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_p     (cnt_p),
    .cnt_x     (cnt_x),
    .cnt_t     (cnt_t)
`ifdef CLS_NONE_EN
    ,
    .cnt_none  (cnt_none)
`endif
  );

  clasif_stats #(.WINDOW(10), .CW(3)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .p_in      (s_p_in),
    .x_in      (1'b0),
    .t_in      (1'b0),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .cnt_p     (s_cnt_p),
    .cnt_x     (s_cnt_x),
    .cnt_t     (s_cnt_t)
`ifdef CLS_NONE_EN
    ,
    .cnt_none  (s_cnt_none)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the main instance's sample inputs and advances to the next falling edge.
  task automatic applyStimulus(input logic v, input logic p, input logic x, input logic t);
    in_valid = v;
    p_in     = p;
    x_in     = x;
    t_in     = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applySatStimulus(input logic v, input logic p);
    s_in_valid = v;
    s_p_in     = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr         = 1'b0;
    in_valid    = 1'b1;
    p_in        = 1'b1;
    x_in        = 1'b1;
    t_in        = 1'b1;
    out_ready   = 1'b0;
    s_in_valid  = 1'b1;
    s_p_in      = 1'b1;
    s_out_ready = 1'b0;

    // Reset held for three cycles with samples offered
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_cnt_p", 32'(cnt_p), 32'd0);
    checkOutput("rst_cnt_x", 32'(cnt_x), 32'd0);
    checkOutput("rst_cnt_t", 32'(cnt_t), 32'd0);
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_s_in_ready", 32'(s_in_ready), 32'd1);

    // Window of values 2, 3, 9, 25
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("win_early_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("win_out_valid", 32'(out_valid), 32'd1);
    checkOutput("win_in_ready", 32'(in_ready), 32'd0);
    checkOutput("win_cnt_p", 32'(cnt_p), 32'd2);
    checkOutput("win_cnt_x", 32'(cnt_x), 32'd1);
    checkOutput("win_cnt_t", 32'(cnt_t), 32'd2);
`ifdef CLS_NONE_EN
    checkOutput("win_cnt_none", 32'(cnt_none), 32'd1);
`endif

    // Backpressure: offered samples must not be counted
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_cnt_p", 32'(cnt_p), 32'd2);
      checkOutput("bp_cnt_t", 32'(cnt_t), 32'd2);
    end
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    checkOutput("hs_out_valid", 32'(out_valid), 32'd0);
    checkOutput("hs_in_ready", 32'(in_ready), 32'd1);
    checkOutput("hs_cnt_hold", 32'(cnt_p), 32'd2);

    // Next window starts from zero
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("w2_out_valid", 32'(out_valid), 32'd1);
    checkOutput("w2_cnt_p", 32'(cnt_p), 32'd4);
    checkOutput("w2_cnt_x", 32'(cnt_x), 32'd0);
    checkOutput("w2_cnt_t", 32'(cnt_t), 32'd0);
`ifdef CLS_NONE_EN
    checkOutput("w2_cnt_none", 32'(cnt_none), 32'd0);
`endif
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;

    // Clear together with an accept discards that sample and the partial window
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    clr = 1'b0;
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_cnt_p", 32'(cnt_p), 32'd0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_no_early", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_out_valid2", 32'(out_valid), 32'd1);
    checkOutput("clr_cnt_x", 32'(cnt_x), 32'd4);
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;

    // Asynchronous reset while a report is pending
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ar_pre_valid", 32'(out_valid), 32'd1);
    checkOutput("ar_pre_cnt_t", 32'(cnt_t), 32'd4);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_cnt_t", 32'(cnt_t), 32'd0);
    checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ar_no_early", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("ar_out_valid2", 32'(out_valid), 32'd1);
    checkOutput("ar_cnt_p", 32'(cnt_p), 32'd4);
    checkOutput("ar_cnt_x", 32'(cnt_x), 32'd4);
    checkOutput("ar_cnt_t2", 32'(cnt_t), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;

    // Saturation: ten primes into a 3-bit count must stop at 7
    for (int i = 0; i < 9; i++) applySatStimulus(1'b1, 1'b1);
    checkOutput("sat_early_valid", 32'(s_out_valid), 32'd0);
    checkOutput("sat_in_ready", 32'(s_in_ready), 32'd1);
    applySatStimulus(1'b1, 1'b1);
    checkOutput("sat_out_valid", 32'(s_out_valid), 32'd1);
    checkOutput("sat_cnt_p", 32'(s_cnt_p), 32'd7);
    checkOutput("sat_cnt_x", 32'(s_cnt_x), 32'd0);
    checkOutput("sat_cnt_t", 32'(s_cnt_t), 32'd0);
`ifdef CLS_NONE_EN
    checkOutput("sat_cnt_none", 32'(s_cnt_none), 32'd0);
`endif
    s_out_ready = 1'b1;
    applySatStimulus(1'b0, 1'b0);
    s_out_ready = 1'b0;
    checkOutput("sat_hs_valid", 32'(s_out_valid), 32'd0);
    checkOutput("sat_hs_ready", 32'(s_in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clasif_stats.md
Name: clasif_stats

Overview:
Downstream consumer of the 5-bit number classifier stage.
- Receives one sample per handshake: the classifier's three flags, p (prime), x (even) and t (multiple of 3).
- Accumulates flag occurrences over a fixed window of WINDOW accepted samples.
- Presents the window totals as one report word under a valid/ready handshake, holding it until it is consumed.

Parameters:
WINDOW, 16, accepted samples per report; legal range 1..255.
CW, 8, width of each count output; counts saturate at 2^CW-1.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of window and report; highest priority after reset
in_valid  input  1  sample present on p_in/x_in/t_in
in_ready  output  1  block accepts a sample this cycle
p_in  input  1  prime flag of current sample
x_in  input  1  even flag of current sample
t_in  input  1  multiple-of-3 flag of current sample
out_valid  output  1  report available
out_ready  input  1  consumer takes report
cnt_p  output  CW  primes in reported window
cnt_x  output  CW  evens in reported window
cnt_t  output  CW  multiples of 3 in reported window

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state=COLLECT, sample counter=0, accumulators=0, out_valid=0, cnt_p/cnt_x/cnt_t=0. in_ready=1 once rst_n is released.
- in_ready is combinational from state: 1 in COLLECT, 0 in REPORT.
- Accept event: in_valid & in_ready at a rising edge. Cycles with in_valid=0 change nothing. in_valid during REPORT is ignored; the sample is not counted.
- COLLECT, accept with sample counter < WINDOW-1:
  - each accumulator increments by 1 if its flag is 1;
  - increment saturates at 2^CW-1 and never wraps;
  - sample counter increments.
- COLLECT, accept of the WINDOW-th sample:
  - cnt_* registers load the accumulator plus this sample's flag, saturated;
  - out_valid=1 on the following cycle (latency 1 from last accept);
  - accumulators and sample counter clear; state goes to REPORT.
- REPORT:
  - out_valid, cnt_p, cnt_x and cnt_t are held stable while out_ready=0;
  - out_valid & out_ready at an edge: out_valid=0 and state=COLLECT next cycle, so in_ready=1 the cycle after the handshake;
  - cnt_* outputs keep their last value after out_valid falls;
  - no combinational path from out_ready to in_ready.
- No flag-consistency checking: any combination of p_in/x_in/t_in is counted as given.
- clr=1 at an edge:
  - state=COLLECT, accumulators=0, sample counter=0, out_valid=0, cnt_*=0;
  - overrides a simultaneous accept and a simultaneous report handshake, so the sample is discarded.
- rst_n low mid-operation, including during REPORT: all outputs go to reset values immediately, without waiting for a clock edge.
- WINDOW=1: every accept produces a report; the block alternates COLLECT/REPORT.
- Sample counter width: $clog2(WINDOW+1).

Optional Feature:
Macro CLS_NONE_EN.
- Defined:
  - adds output port cnt_none (output, CW bits), counting samples with p_in=x_in=t_in=0 (e.g. values 1 and 25);
  - same accumulate, saturate, load, clear and reset rules as the other counts.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, all cnt_*=0; in_ready=1 after release.
- WINDOW=4, four accepts with flags for values 2(p,x), 3(p,t), 9(t), 25(none) -> out_valid=1 one cycle after the 4th accept with cnt_p=2, cnt_x=1, cnt_t=2 (cnt_none=1 when CLS_NONE_EN).
- Backpressure: report pending, out_ready=0 for 5 cycles while in_valid=1 -> out_valid and counts stable, in_ready=0, nothing counted. Then out_ready=1 -> out_valid=0 and in_ready=1 next cycle, next window starts from 0.
- Saturation, CW=3 and WINDOW=10: ten samples with p_in=1 -> cnt_p=7, no wrap to 2.
- Clear, WINDOW=4: accept 2 samples with x_in=1, pulse clr together with a 3rd accept, then 4 samples with x_in=1 -> report cnt_x=4 and only one report issued.
- Async reset during REPORT: assert rst_n=0 mid-cycle -> out_valid drops before the next clk edge; after release, a full new window is required for the next report.
